// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Consumer-side burst reader for an 8-deep synchronous FIFO.
//                Pops exactly `len` words over the EN/RD/EMPTY/dataOut port,
//                absorbs the 1-cycle read latency in a 2-entry skid buffer,
//                streams words on valid/ready, then pulses done.
//  Option      : define FIFO_BURST_READER_STATS_EN to add stat_words and
//                stat_stalls saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              fifo_EN,
   output logic              fifo_RD,
   input  logic              fifo_EMPTY,
   input  logic [DATA_W-1:0] fifo_dataOut,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready
`ifdef FIFO_BURST_READER_STATS_EN
   ,
   output logic [31:0]       stat_words,
   output logic [31:0]       stat_stalls
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [LEN_W-1:0]    r_issue_rem;
   logic [LEN_W-1:0]    r_deliv_rem;
   logic                r_inflight;
   logic [1:0]          r_occ;
   logic [DATA_W-1:0]   r_buf0;
   logic [DATA_W-1:0]   r_buf1;
   logic                r_done;

   logic                w_run;
   logic                w_pop;
   logic [2:0]          w_pending;
   logic                w_space;
   logic                w_rd;
   logic                w_cap;
   logic                w_last;
   logic                w_accept;
   logic                w_abort_run;
   logic                w_done_nxt;

   // Words held or on their way back; a new read is only allowed while
   // this stays below the buffer depth, which is what prevents overflow.
   assign w_run       = (r_state == S_RUN);
   assign w_pop       = dout_valid && dout_ready;
   assign w_pending   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_space     = (w_pending < 3'd2);
   assign w_abort_run = w_run && abort;
   assign w_rd        = w_run && !Rst && !abort && !fifo_EMPTY
                        && (r_issue_rem != '0) && w_space;
   assign w_cap       = w_run && r_inflight;
   assign w_last      = w_pop && (r_deliv_rem == LEN_W'(1));
   assign w_accept    = (r_state == S_IDLE) && start && (len != '0);

   assign fifo_EN    = !Rst;
   assign dout_valid = (r_occ != 2'd0);
   assign dout       = r_buf0;
   assign done       = r_done;

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode, read strobe, busy and done request.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      fifo_RD     = w_rd;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start && (len != '0)) begin
               w_state_nxt = S_RUN;
            end else if (start) begin
               w_done_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = r_inflight ? S_FLUSH : S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         S_FLUSH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Done pulse, registered so it lands one cycle after the last handshake.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
      end
   end

   // Issue / delivery counters and the read-latency tracker.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_issue_rem <= '0;
         r_deliv_rem <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_inflight <= w_rd;
         if (w_accept) begin
            r_issue_rem <= len;
            r_deliv_rem <= len;
         end else if (w_abort_run) begin
            r_issue_rem <= '0;
            r_deliv_rem <= '0;
         end else begin
            if (w_rd) begin
               r_issue_rem <= r_issue_rem - LEN_W'(1);
            end
            if (w_pop && (r_deliv_rem != '0)) begin
               r_deliv_rem <= r_deliv_rem - LEN_W'(1);
            end
         end
      end
   end

   // Two-entry in-order skid buffer; r_buf0 is always the head.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_occ  <= 2'd0;
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else if (w_abort_run) begin
         r_occ <= 2'd0;
      end else begin
         case ({w_cap, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_buf0 <= fifo_dataOut;
               end else begin
                  r_buf1 <= fifo_dataOut;
               end
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_buf0 <= fifo_dataOut;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= fifo_dataOut;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FIFO_BURST_READER_STATS_EN
   logic [31:0] r_stat_words;
   logic [31:0] r_stat_stalls;
   logic        w_stall;

   assign w_stall     = w_run && (r_issue_rem != '0) && w_space && fifo_EMPTY;
   assign stat_words  = r_stat_words;
   assign stat_stalls = r_stat_stalls;

   // Saturating handshake and FIFO-starvation counters.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_stat_words  <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_pop && (r_stat_words != '1)) begin
            r_stat_words <= r_stat_words + 32'd1;
         end
         if (w_stall && (r_stat_stalls != '1)) begin
            r_stat_stalls <= r_stat_stalls + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer-side controller for the team's 8-deep, 32-bit synchronous FIFO.
- On a start request it pops exactly `len` words through the FIFO's EN/RD/EMPTY/dataOut read port and absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer.
- It presents the words on a valid/ready stream at full throughput, then pulses done.
- Sits between the FIFO and any downstream consumer (DMA, serializer).

Parameters:
- DATA_W, 32, width of FIFO data and stream data.
- LEN_W, 8, width of burst length request; max burst 2^LEN_W-1 words.

Ports:
- Clk  input  1  clock; all logic on posedge.
- Rst  input  1  reset.
- start  input  1  burst request pulse; accepted only in IDLE.
- len  input  LEN_W  burst length, sampled with accepted start.
- abort  input  1  cancel current burst.
- busy  output  1  high in RUN or FLUSH.
- done  output  1  1-cycle pulse when the final word of a burst is accepted downstream.
- fifo_EN  output  1  FIFO enable; high whenever Rst is low.
- fifo_RD  output  1  FIFO read strobe.
- fifo_EMPTY  input  1  FIFO empty flag.
- fifo_dataOut  input  DATA_W  FIFO read data; valid the cycle after a sampled fifo_RD.
- dout  output  DATA_W  stream data (head of skid buffer).
- dout_valid  output  1  stream valid.
- dout_ready  input  1  stream ready.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, Clk / Rst.
  - Rst high: state=IDLE, busy=0, done=0, fifo_RD=0, fifo_EN=0, dout_valid=0, dout=0, buffer occupancy occ=0, inflight=0, counters=0.
  - Rst overrides start/abort. Rst mid-burst discards everything; no done pulse.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 and len!=0: load issue_rem=len and deliv_rem=len; go RUN next cycle.
  - start=1 and len==0: done pulses the next cycle; stay IDLE.
  - start is ignored while busy.
- RUN, read issue:
  - Combinational rule: fifo_RD = !fifo_EMPTY && issue_rem!=0 && (occ + inflight - pop) < 2, where pop = dout_valid && dout_ready in the same cycle.
  - On fifo_RD: issue_rem--, inflight=1 next cycle.
- RUN, capture:
  - When inflight=1, fifo_dataOut is written into the buffer tail the same cycle.
  - Buffer is in-order, 2 entries. The no-overflow guarantee comes from the issue rule.
- Stream:
  - dout_valid = (occ!=0). dout = oldest entry.
  - dout holds stable while dout_valid && !dout_ready.
  - Handshake (pop): deliv_rem--.
  - Simultaneous capture and pop: occ unchanged; order preserved.
- Throughput: with FIFO non-empty and dout_ready held 1, one word per cycle after a 2-cycle start latency.
  - Accepted start at edge N → first fifo_RD in cycle N+1 → dout_valid in cycle N+2.
- Burst end: pop that takes deliv_rem 1→0 → done=1 in the following cycle, busy=0, state=IDLE.
- FIFO empty mid-burst: fifo_RD held low, no bubble corruption; resumes when fifo_EMPTY drops.
- Abort (RUN):
  - fifo_RD forced 0 that cycle; buffer cleared (occ=0, dout_valid=0) next cycle.
  - inflight=1: go FLUSH for one cycle to discard the returning word, then IDLE.
  - inflight=0: go directly to IDLE.
  - No done pulse on abort.
- Width rules: counters LEN_W bits, never wrap (issue and delivery are gated at zero). occ is 2 bits, max 2.

Optional Feature:
- Macro FIFO_BURST_READER_STATS_EN.
- Defined: adds outputs stat_words [31:0] and stat_stalls [31:0].
  - stat_words increments on every stream handshake.
  - stat_stalls increments each RUN cycle in which issue_rem!=0, space exists and fifo_EMPTY=1.
  - Both saturate at all-ones; cleared only by Rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Basic burst: FIFO preloaded with 0x11..0x15, start len=5, dout_ready=1 → dout 0x11..0x15 on 5 consecutive cycles; fifo_RD asserted exactly 5 cycles; done pulses once, one cycle after the last handshake.
- Backpressure: len=4, dout_ready toggles 1,0,0,1,... → no word lost or duplicated; occ never >2; dout stable while stalled.
- Underflow: FIFO holds 2 words, len=4; write 2 more words 10 cycles later → fifo_RD stays 0 while empty; all 4 words delivered in order; done after the 4th.
- Abort mid-burst: len=6, abort after 2 handshakes while inflight=1 → FLUSH for 1 cycle, IDLE, no done; FIFO count reduced by exactly the number of RD strobes issued.
- Reset mid-burst: Rst for 1 cycle during RUN → next cycle all outputs at reset values; a new start len=1 works normally.
- Zero and ignored start: start len=0 → done the next cycle with no fifo_RD; start pulsed while busy → ignored; burst length unchanged.
